counter_load_arbiter: RTL and testbench

Arbitrates write access to the 64-bit Unix-time counter's load port among several requesters: manual adjust, external time sync and alarm/snooze rewrite. Sits between those requesters and the counter's `load_n`/`setCounter` inputs in the clock top level. Grants one requester at a time in round-robin order, drives an active-low load strobe of fixed length, then acknowledges the winner. A lock input gives the manual-adjust requester exclusive access while the user is in adjust mode.

---
 rtl/counter_load_arbiter_pkg.sv | 17 +
 rtl/counter_load_arbiter_rr_priority_pick.sv | 32 +++
 rtl/counter_load_arbiter.sv | 113 +++++++++++
 tb/tb_counter_load_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_load_arbiter_pkg.sv
// Shared definitions for the Unix-time counter load arbiter:
// counter width, FSM encodings and requester indices.
package counter_load_arbiter_pkg;

    localparam int CNT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int REQ_ADJUST = 0;
    localparam int REQ_SYNC   = 1;
    localparam int REQ_ALARM  = 2;

endpackage

// File: rtl/counter_load_arbiter_rr_priority_pick.sv
// Combinational rotating-priority encoder: first eligible
// requester at or after ptr, wrapping modulo N_REQ.
module rr_priority_pick #(
    parameter int N_REQ = 3,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    idx
);

    logic [PW:0] pos;

    // Scan farthest-first so the closest hit to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N_REQ)) begin
                pos = pos - (PW + 1)'(N_REQ);
            end
            if (eligible[pos[PW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter driving the time counter's load strobe
// and load value; lock reserves the port for manual adjust.
module counter_load_arbiter
    import counter_load_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int W     = CNT_W,
    parameter int HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lock,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_value,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               load_n,
    output logic [W-1:0]       set_counter
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [N_REQ-1:0] ONLY_ADJ = N_REQ'(1);

    state_e             state_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [PW-1:0]      win_q;
    logic [HW-1:0]      hold_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               busy_q;
    logic               load_n_q;
    logic [W-1:0]       set_counter_q;

    logic [N_REQ-1:0]   eligible;
    logic               pick_valid;
    logic [PW-1:0]      pick_idx;
    logic [W-1:0]       vals [N_REQ];

    assign eligible = req & (lock ? ONLY_ADJ : {N_REQ{1'b1}});

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            vals[i] = req_value[i*W +: W];
        end
    end

    always_comb begin
        ptr_d = win_q + 1'b1;
        if (win_q == PW'(N_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            hold_q        <= '0;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            load_n_q      <= 1'b1;
            set_counter_q <= '0;
        end else begin
            gnt_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        win_q         <= pick_idx;
                        set_counter_q <= vals[pick_idx];
                        hold_q        <= '0;
                        load_n_q      <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= LOAD;
                    end
                end
                LOAD: begin
                    if (hold_q == HW'(HOLD - 1)) begin
                        hold_q   <= '0;
                        load_n_q <= 1'b1;
                        gnt_q    <= ONLY_ADJ << win_q;
                        state_q  <= ACK;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ACK: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign load_n      = load_n_q;
    assign set_counter = set_counter_q;

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Directed bench for counter_load_arbiter: timing, rotation,
// lock, value stability, request drop and mid-load reset.
module tb_counter_load_arbiter;

    localparam int N = 3;
    localparam int W = 64;

    logic           clk;
    logic           rst_n;
    logic           lock;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_value;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           load_n;
    logic [W-1:0]   set_counter;

    int checks   = 0;
    int failures = 0;

    counter_load_arbiter #(
        .N_REQ (N),
        .W     (W),
        .HOLD  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock        (lock),
        .req         (req),
        .req_value   (req_value),
        .gnt         (gnt),
        .busy        (busy),
        .load_n      (load_n),
        .set_counter (set_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_value = '0;
        do_reset();
        checks++;
        if (load_n !== 1'b1 || gnt !== 3'b000 || busy !== 1'b0
            || set_counter !== 64'd0) begin
            failures++;
            $display("FAIL reset: load_n=%b gnt=%b busy=%b set=%0d need 1/000/0/0",
                     load_n, gnt, busy, set_counter);
        end
    endtask

    task automatic test_single();
        req_value[1*W +: W] = 64'd1725330000;
        req = 3'b010;
        @(negedge clk);
        checks++;
        if (load_n !== 1'b0 || busy !== 1'b1 || set_counter !== 64'd1725330000) begin
            failures++;
            $display("FAIL single_c1: load_n=%b busy=%b set=%0d need 0/1/1725330000",
                     load_n, busy, set_counter);
        end
        @(negedge clk);
        checks++;
        if (load_n !== 1'b0 || gnt !== 3'b000) begin
            failures++;
            $display("FAIL single_c2: load_n=%b gnt=%b need 0/000", load_n, gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010 || load_n !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_c3: gnt=%b load_n=%b busy=%b need 010/1/1",
                     gnt, load_n, busy);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 3'b000 || set_counter !== 64'd1725330000) begin
            failures++;
            $display("FAIL single_c4: busy=%b gnt=%b set=%0d need 0/000/1725330000",
                     busy, gnt, set_counter);
        end
    endtask

    task automatic test_round_robin();
        int cyc  = 0;
        int last = -1;
        int t    = 0;
        logic [N-1:0] exp_g;
        do_reset();
        req_value[0*W +: W] = 64'd10;
        req_value[1*W +: W] = 64'd11;
        req_value[2*W +: W] = 64'd12;
        req = 3'b111;
        while (t < 9 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (gnt !== 3'b000) begin
                exp_g = 3'b001 << (t % 3);
                checks++;
                if (gnt !== exp_g || set_counter !== 64'(10 + t % 3)) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: gnt=%b set=%0d need %b/%0d",
                             t, gnt, set_counter, exp_g, 10 + t % 3);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 4) begin
                        failures++;
                        $display("FAIL rr_spacing[%0d]: got %0d cycles need 4",
                                 t, cyc - last);
                    end
                end
                last = cyc;
                t++;
            end
        end
        req = '0;
        checks++;
        if (t !== 9) begin
            failures++;
            $display("FAIL rr_timeout: got %0d grants need 9", t);
        end
        @(negedge clk);
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int n);
        g = '0;
        n = 0;
        while (g === '0 && n < 20) begin
            @(negedge clk);
            n++;
            g = gnt;
        end
    endtask

    task automatic test_lock();
        int bad = 0;
        int n;
        logic [N-1:0] g;
        lock = 1'b1;
        req  = 3'b110;
        repeat (20) begin
            @(negedge clk);
            if (load_n !== 1'b1 || busy !== 1'b0 || gnt !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL lock_block: %0d active cycles need 0", bad);
        end
        req_value[0*W +: W] = 64'd42;
        req = 3'b111;
        wait_gnt(g, n);
        checks++;
        if (g !== 3'b001 || n !== 3 || set_counter !== 64'd42) begin
            failures++;
            $display("FAIL lock_adj: gnt=%b after %0d set=%0d need 001/3/42",
                     g, n, set_counter);
        end
        req  = 3'b110;
        lock = 1'b0;
        wait_gnt(g, n);
        checks++;
        if (g !== 3'b010) begin
            failures++;
            $display("FAIL lock_release: gnt=%b need 010", g);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_value_change();
        int n;
        logic [N-1:0] g;
        req_value[0*W +: W] = 64'd100;
        req = 3'b001;
        @(negedge clk);
        req_value[0*W +: W] = 64'd200;
        @(negedge clk);
        checks++;
        if (set_counter !== 64'd100 || load_n !== 1'b0) begin
            failures++;
            $display("FAIL value_hold: set=%0d load_n=%b need 100/0",
                     set_counter, load_n);
        end
        wait_gnt(g, n);
        checks++;
        if (g !== 3'b001 || set_counter !== 64'd100) begin
            failures++;
            $display("FAIL value_gnt: gnt=%b set=%0d need 001/100", g, set_counter);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        int n;
        logic [N-1:0] g;
        req_value[2*W +: W] = 64'd3000;
        req = 3'b100;
        @(negedge clk);
        req  = '0;
        lock = 1'b1;
        wait_gnt(g, n);
        checks++;
        if (g !== 3'b100 || n !== 2 || set_counter !== 64'd3000) begin
            failures++;
            $display("FAIL req_drop: gnt=%b after %0d set=%0d need 100/2/3000",
                     g, n, set_counter);
        end
        lock = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int n;
        logic [N-1:0] g;
        req_value[0*W +: W] = 64'd555;
        req = 3'b001;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (load_n !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: load_n=%b need 0", load_n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (load_n !== 1'b1 || busy !== 1'b0 || set_counter !== 64'd0) begin
            failures++;
            $display("FAIL rstmid_async: load_n=%b busy=%b set=%0d need 1/0/0",
                     load_n, busy, set_counter);
        end
        req = '0;
        repeat (2) begin
            @(negedge clk);
            if (gnt !== 3'b000) bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (gnt !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rstmid_nognt: %0d stray grants need 0", bad);
        end
        req_value[0*W +: W] = 64'd777;
        req = 3'b001;
        wait_gnt(g, n);
        checks++;
        if (g !== 3'b001 || n !== 3 || set_counter !== 64'd777) begin
            failures++;
            $display("FAIL rstmid_fresh: gnt=%b after %0d set=%0d need 001/3/777",
                     g, n, set_counter);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle: busy=%b need 0", busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        lock      = 1'b0;
        req       = '0;
        req_value = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_value_change();
        test_req_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
